rvfi_retire_comparator: RTL
===========================

// Module: rvfi_retire_comparator
// PURPOSE
// Consumes the reference-model RVFI retirement stream produced by the ISS pipeline shell.
// Also consumes the DUT RVFI retirement stream, and pairs retirements in order.
// Per-side FIFOs absorb skew between the two streams, since either side may lead by up to DEPTH retirements.
// Each pair is compared field by field; the block reports mismatches and keeps pass/fail counters for the testbench.
// PARAMETERS
// XLEN              32  data/PC width
// DEPTH             8   entries per side FIFO (power of 2, >=2)
// CNT_W             32  width of match/mismatch counters
// STOP_ON_MISMATCH  1   1: freeze comparison after first mismatch
// PORTS
// clk_i             in   1        clock
// rst_i             in   1        reset, asynchronous, active-high
// dut_valid_i       in   1        DUT retirement valid (one per cycle max)
// dut_order_i       in   64       DUT rvfi_order
// dut_insn_i        in   32       DUT instruction word
// dut_trap_i        in   1        DUT trap flag
// dut_pc_rdata_i    in   XLEN     DUT PC of retired instr
// dut_rd1_addr_i    in   5        DUT rd address
// dut_rd1_wdata_i   in   XLEN     DUT rd write data
// ref_valid_i       in   1        ISS retirement valid
// ref_*_i           in   same     ISS fields mirroring dut_*_i (order, insn, trap, pc_rdata, rd1_addr, rd1_wdata)
// mismatch_o        out  1        1-cycle pulse: compared pair differed
// mismatch_fields_o out  5        {rd,trap,insn,pc,order} diff bits of last mismatch (held)
// halted_o          out  1        sticky; set on first mismatch when STOP_ON_MISMATCH=1
// overflow_o        out  1        sticky; a push was dropped on a full FIFO
// match_cnt_o       out  CNT_W    pairs compared equal, saturating
// mismatch_cnt_o    out  CNT_W    pairs compared unequal, saturating
// dut_level_o       out  clog2(DEPTH)+1  DUT FIFO occupancy
// ref_level_o       out  clog2(DEPTH)+1  ref FIFO occupancy
// BEHAVIOUR
// - Reset (async assert, sync release): FIFOs empty, pointers 0, all outputs 0.
// - Push: each side's FIFO captures its fields on valid when the FIFO is not full.
// - Push also accepted when full if the same cycle pops that FIFO (full+pop+push keeps level at DEPTH).
// - Push on full without pop: entry dropped, overflow_o <= 1 (sticky), level unchanged.
// - Pop/compare: when both FIFOs are non-empty and !halted_o, pop both heads in the same cycle.
// - Pop/compare rate: at most one pair per cycle; registered result.
// - Latency: valid to both-present is 1 cycle (the FIFO write), plus 1 cycle for the registered compare.
// - Latency example: both valid at cycle N -> pair popped at N+1 -> mismatch_o/counters update at N+2.
// - Compare rules: order, pc_rdata, insn, trap compared exactly.
// - rd compare: rd1_addr must be equal; rd1_wdata is compared only when rd1_addr != 0.
// - rd compare: when rd1_addr == 0, wdata is ignored.
// - Equal pair: match_cnt_o += 1.
// - Unequal pair: mismatch_cnt_o += 1, mismatch_o pulses, mismatch_fields_o loads the diff vector.
// - Counters saturate at all-ones; no wrap.
// - mismatch_fields_o holds until the next mismatch or reset.
// - STOP_ON_MISMATCH=1: halted_o sets in the same cycle as the mismatch_o pulse.
// - STOP_ON_MISMATCH=1, after halt: no further pops, FIFOs continue filling until full (then overflow).
// - Only reset clears halt.
// - Pointer wrap: read/write pointers are clog2(DEPTH)+1 bits.
// - Full when MSBs differ and the low bits are equal; empty when the pointers are equal.
// - Reset mid-stream: all in-flight entries discarded; no mismatch_o pulse is generated by reset.
// TESTING
// - 4 identical retirements, both valid same cycles -> match_cnt_o=4, mismatch_cnt_o=0, levels return 0.
// - DUT leads by 5 (ref starts 5 cycles later), DEPTH=8 -> dut_level_o peaks 6, no overflow, match_cnt_o=N.
// - Ref pc_rdata=0x80000004 vs DUT 0x80000008 on pair 3 -> mismatch_o at pair+2 cycles, fields=5'b00010.
// - Halt case (continues the previous scenario): with STOP_ON_MISMATCH=1, halted_o=1 and match_cnt_o stays 2.
// - rd1_addr=0 on both sides, wdata 0x1 vs 0x2 -> counted as match.
// - rd1_addr=5 on both sides, wdata 0x1 vs 0x2 -> mismatch, fields=5'b10000.
// - DUT pushes 9 entries with ref idle, DEPTH=8 -> overflow_o=1, dut_level_o=8.
// - rst_i asserted mid-run -> levels/counters/flags 0 immediately, no mismatch_o pulse.

Source files
------------

// File: rtl/rvfi_retire_comparator.sv
// rvfi_retire_comparator: pairs DUT and reference RVFI retirements in order
// through per-side FIFOs, compares each pair field by field and keeps
// saturating match/mismatch counters plus sticky halt/overflow flags.
module rvfi_retire_comparator #(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned DEPTH            = 8,
    parameter int unsigned CNT_W            = 32,
    parameter bit          STOP_ON_MISMATCH = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     dut_valid_i,
    input  logic [63:0]              dut_order_i,
    input  logic [31:0]              dut_insn_i,
    input  logic                     dut_trap_i,
    input  logic [XLEN-1:0]          dut_pc_rdata_i,
    input  logic [4:0]               dut_rd1_addr_i,
    input  logic [XLEN-1:0]          dut_rd1_wdata_i,
    input  logic                     ref_valid_i,
    input  logic [63:0]              ref_order_i,
    input  logic [31:0]              ref_insn_i,
    input  logic                     ref_trap_i,
    input  logic [XLEN-1:0]          ref_pc_rdata_i,
    input  logic [4:0]               ref_rd1_addr_i,
    input  logic [XLEN-1:0]          ref_rd1_wdata_i,
    output logic                     mismatch_o,
    output logic [4:0]               mismatch_fields_o,
    output logic                     halted_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         match_cnt_o,
    output logic [CNT_W-1:0]         mismatch_cnt_o,
    output logic [$clog2(DEPTH):0]   dut_level_o,
    output logic [$clog2(DEPTH):0]   ref_level_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    typedef struct packed {
        logic [63:0]     order;
        logic [31:0]     insn;
        logic            trap;
        logic [XLEN-1:0] pc_rdata;
        logic [4:0]      rd1_addr;
        logic [XLEN-1:0] rd1_wdata;
    } retire_t;

    retire_t            dut_mem [DEPTH];
    retire_t            ref_mem [DEPTH];
    logic [PTR_W-1:0]   dut_wptr_q, dut_rptr_q;
    logic [PTR_W-1:0]   ref_wptr_q, ref_rptr_q;

    retire_t            dut_entry_c, ref_entry_c;
    retire_t            dut_head_c, ref_head_c;
    logic               dut_full_c, dut_empty_c, ref_full_c, ref_empty_c;
    logic               pop_c;
    logic               dut_push_c, ref_push_c, dut_drop_c, ref_drop_c;
    logic [4:0]         diff_c;

    // Pack incoming retirement fields and read FIFO heads
    always_comb begin
        dut_entry_c = '{order: dut_order_i, insn: dut_insn_i, trap: dut_trap_i,
                        pc_rdata: dut_pc_rdata_i, rd1_addr: dut_rd1_addr_i,
                        rd1_wdata: dut_rd1_wdata_i};
        ref_entry_c = '{order: ref_order_i, insn: ref_insn_i, trap: ref_trap_i,
                        pc_rdata: ref_pc_rdata_i, rd1_addr: ref_rd1_addr_i,
                        rd1_wdata: ref_rd1_wdata_i};
        dut_head_c  = dut_mem[dut_rptr_q[AW-1:0]];
        ref_head_c  = ref_mem[ref_rptr_q[AW-1:0]];
    end

    // FIFO status, pop/push decisions; a full FIFO still accepts when popped
    always_comb begin
        dut_full_c  = (dut_wptr_q[AW] != dut_rptr_q[AW]) &&
                      (dut_wptr_q[AW-1:0] == dut_rptr_q[AW-1:0]);
        ref_full_c  = (ref_wptr_q[AW] != ref_rptr_q[AW]) &&
                      (ref_wptr_q[AW-1:0] == ref_rptr_q[AW-1:0]);
        dut_empty_c = (dut_wptr_q == dut_rptr_q);
        ref_empty_c = (ref_wptr_q == ref_rptr_q);
        pop_c       = !dut_empty_c && !ref_empty_c && !halted_o;
        dut_push_c  = dut_valid_i && (!dut_full_c || pop_c);
        ref_push_c  = ref_valid_i && (!ref_full_c || pop_c);
        dut_drop_c  = dut_valid_i && dut_full_c && !pop_c;
        ref_drop_c  = ref_valid_i && ref_full_c && !pop_c;
    end

    // Field diff vector {rd,trap,insn,pc,order}; rd wdata ignored for x0
    always_comb begin
        diff_c    = 5'd0;
        diff_c[0] = (dut_head_c.order    != ref_head_c.order);
        diff_c[1] = (dut_head_c.pc_rdata != ref_head_c.pc_rdata);
        diff_c[2] = (dut_head_c.insn     != ref_head_c.insn);
        diff_c[3] = (dut_head_c.trap     != ref_head_c.trap);
        diff_c[4] = (dut_head_c.rd1_addr != ref_head_c.rd1_addr) ||
                    ((dut_head_c.rd1_addr != 5'd0) &&
                     (dut_head_c.rd1_wdata != ref_head_c.rd1_wdata));
    end

    // FIFO storage writes; contents need no reset since pointers gate them
    always_ff @(posedge clk_i) begin
        if (dut_push_c) dut_mem[dut_wptr_q[AW-1:0]] <= dut_entry_c;
        if (ref_push_c) ref_mem[ref_wptr_q[AW-1:0]] <= ref_entry_c;
    end

    // Pointers, occupancy levels and sticky overflow flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dut_wptr_q  <= '0;
            dut_rptr_q  <= '0;
            ref_wptr_q  <= '0;
            ref_rptr_q  <= '0;
            dut_level_o <= '0;
            ref_level_o <= '0;
            overflow_o  <= 1'b0;
        end else begin
            if (dut_push_c) dut_wptr_q <= dut_wptr_q + PTR_W'(1);
            if (ref_push_c) ref_wptr_q <= ref_wptr_q + PTR_W'(1);
            if (pop_c) begin
                dut_rptr_q <= dut_rptr_q + PTR_W'(1);
                ref_rptr_q <= ref_rptr_q + PTR_W'(1);
            end
            dut_level_o <= dut_level_o + PTR_W'(dut_push_c) - PTR_W'(pop_c);
            ref_level_o <= ref_level_o + PTR_W'(ref_push_c) - PTR_W'(pop_c);
            if (dut_drop_c || ref_drop_c) overflow_o <= 1'b1;
        end
    end

    // Registered compare result, saturating counters and halt
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mismatch_o        <= 1'b0;
            mismatch_fields_o <= 5'd0;
            halted_o          <= 1'b0;
            match_cnt_o       <= '0;
            mismatch_cnt_o    <= '0;
        end else begin
            mismatch_o <= 1'b0;
            if (pop_c) begin
                if (diff_c == 5'd0) begin
                    if (match_cnt_o != {CNT_W{1'b1}})
                        match_cnt_o <= match_cnt_o + CNT_W'(1);
                end else begin
                    mismatch_o        <= 1'b1;
                    mismatch_fields_o <= diff_c;
                    if (mismatch_cnt_o != {CNT_W{1'b1}})
                        mismatch_cnt_o <= mismatch_cnt_o + CNT_W'(1);
                    if (STOP_ON_MISMATCH) halted_o <= 1'b1;
                end
            end
        end
    end

endmodule
